// File: rtl/alarm_clock_controller.sv
// Mode controller for the alarm clock: sequences time/alarm counter enables,
// manual setting, alarm arming and the buzzer. All outputs are registered.
module alarm_clock_controller #(
  parameter int unsigned RING_SECONDS = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_alarm,
  input  logic       sec_tc,
  input  logic       min_tc,
  input  logic       alarm_match,
  output logic       sec_en,
  output logic       sec_clr,
  output logic       min_en,
  output logic       hour_en,
  output logic       alm_min_en,
  output logic       alm_hour_en,
  output logic       cnt_dir,
  output logic [2:0] mode,
  output logic       alarm_armed,
  output logic       buzzer,
  output logic       blink
);

  localparam logic [2:0] CLOCK        = 3'd0;
  localparam logic [2:0] SET_CLK_HOUR = 3'd1;
  localparam logic [2:0] SET_CLK_MIN  = 3'd2;
  localparam logic [2:0] SET_ALM_HOUR = 3'd3;
  localparam logic [2:0] SET_ALM_MIN  = 3'd4;
  localparam logic [2:0] RINGING      = 3'd5;

  localparam logic [7:0] RING_LAST = 8'(RING_SECONDS - 1);

  logic [2:0] state;
  logic       match_prev;
  logic [7:0] ring_cnt;
  logic       adjust;
  logic       match_rise;

  assign mode = state;

  // Simultaneous up and down cancel; a mode press always drops the adjust.
  always_comb begin
    adjust     = (btn_up ^ btn_down) & ~btn_mode;
    match_rise = alarm_match & ~match_prev;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= CLOCK;
      match_prev  <= 1'b0;
      ring_cnt    <= '0;
      sec_en      <= 1'b0;
      sec_clr     <= 1'b0;
      min_en      <= 1'b0;
      hour_en     <= 1'b0;
      alm_min_en  <= 1'b0;
      alm_hour_en <= 1'b0;
      cnt_dir     <= 1'b1;
      alarm_armed <= 1'b0;
      buzzer      <= 1'b0;
      blink       <= 1'b0;
    end else begin
      sec_en      <= 1'b0;
      sec_clr     <= 1'b0;
      min_en      <= 1'b0;
      hour_en     <= 1'b0;
      alm_min_en  <= 1'b0;
      alm_hour_en <= 1'b0;
      match_prev  <= alarm_match;

      if ((state == CLOCK || state == RINGING) && tick_1hz) begin
        sec_en  <= 1'b1;
        min_en  <= sec_tc;
        hour_en <= sec_tc & min_tc;
        cnt_dir <= 1'b1;
      end

      case (state)
        CLOCK: begin
          blink <= 1'b0;
          if (btn_alarm) alarm_armed <= ~alarm_armed;
          if (match_rise && alarm_armed) begin
            state    <= RINGING;
            ring_cnt <= '0;
            buzzer   <= 1'b1;
          end else if (btn_mode) begin
            state   <= SET_CLK_HOUR;
            sec_clr <= 1'b1;
          end
        end

        SET_CLK_HOUR, SET_CLK_MIN, SET_ALM_HOUR, SET_ALM_MIN: begin
          if (btn_mode) begin
            state <= (state == SET_ALM_MIN) ? CLOCK : state + 3'd1;
            blink <= 1'b0;
          end else begin
            if (tick_1hz) blink <= ~blink;
            if (adjust) begin
              cnt_dir <= btn_up;
              case (state)
                SET_CLK_HOUR: hour_en     <= 1'b1;
                SET_CLK_MIN:  min_en      <= 1'b1;
                SET_ALM_HOUR: alm_hour_en <= 1'b1;
                default:      alm_min_en  <= 1'b1;
              endcase
            end
          end
        end

        RINGING: begin
          if (btn_alarm || (tick_1hz && ring_cnt == RING_LAST)) begin
            state    <= CLOCK;
            buzzer   <= 1'b0;
            ring_cnt <= '0;
          end else if (tick_1hz) begin
            ring_cnt <= ring_cnt + 8'd1;
          end
        end

        default: begin
          state    <= CLOCK;
          buzzer   <= 1'b0;
          blink    <= 1'b0;
          ring_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_clock_controller.sv
// Directed self-checking bench for alarm_clock_controller.
module tb_alarm_clock_controller;

  logic       clk = 1'b0;
  logic       reset, tick_1hz, btn_mode, btn_up, btn_down, btn_alarm;
  logic       sec_tc, min_tc, alarm_match;
  logic       sec_en, sec_clr, min_en, hour_en, alm_min_en, alm_hour_en;
  logic       cnt_dir, alarm_armed, buzzer, blink;
  logic [2:0] mode;

  int unsigned total = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  alarm_clock_controller #(.RING_SECONDS(60)) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .btn_mode(btn_mode),
    .btn_up(btn_up), .btn_down(btn_down), .btn_alarm(btn_alarm),
    .sec_tc(sec_tc), .min_tc(min_tc), .alarm_match(alarm_match),
    .sec_en(sec_en), .sec_clr(sec_clr), .min_en(min_en), .hour_en(hour_en),
    .alm_min_en(alm_min_en), .alm_hour_en(alm_hour_en), .cnt_dir(cnt_dir),
    .mode(mode), .alarm_armed(alarm_armed), .buzzer(buzzer), .blink(blink)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs already set are sampled at the edge, then pulses drop.
  task automatic cyc();
    @(posedge clk);
    #1;
    tick_1hz = 0; btn_mode = 0; btn_up = 0; btn_down = 0; btn_alarm = 0;
  endtask

  initial begin
    reset = 1; tick_1hz = 1; btn_mode = 1; btn_up = 1; btn_down = 1; btn_alarm = 1;
    sec_tc = 0; min_tc = 0; alarm_match = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_mode", mode, 0);
    chk("rst_en", {sec_en, sec_clr, min_en, hour_en, alm_min_en, alm_hour_en}, 0);
    chk("rst_dir", cnt_dir, 1);
    chk("rst_flags", {alarm_armed, buzzer, blink}, 0);
    reset = 0; tick_1hz = 0; btn_mode = 0; btn_up = 0; btn_down = 0; btn_alarm = 0;
    cyc();
    chk("idle_en", sec_en, 0);

    // Timekeeping cascade
    sec_tc = 1; min_tc = 1; tick_1hz = 1; cyc();
    chk("tick_cascade", {sec_en, min_en, hour_en}, 3'b111);
    cyc();
    chk("tick_pulse1", {sec_en, min_en, hour_en}, 3'b000);
    sec_tc = 0; min_tc = 1; tick_1hz = 1; cyc();
    chk("tick_nosec_tc", {sec_en, min_en, hour_en}, 3'b100);

    // Setting sequence
    btn_mode = 1; cyc();
    chk("set_hr_mode", mode, 1);
    chk("set_hr_clr", sec_clr, 1);
    cyc();
    chk("clr_pulse1", sec_clr, 0);
    btn_down = 1; cyc();
    chk("hr_down", {hour_en, cnt_dir}, 2'b10);
    cyc();
    chk("hr_dir_hold", {hour_en, cnt_dir}, 2'b00);
    tick_1hz = 1; cyc();
    chk("set_tick_sec", sec_en, 0);
    chk("set_tick_blink", blink, 1);
    btn_up = 1; btn_down = 1; cyc();
    chk("updown_cancel", {hour_en, min_en, cnt_dir}, 3'b000);
    btn_up = 1; cyc();
    chk("hr_up", {hour_en, cnt_dir}, 2'b11);
    btn_mode = 1; cyc();
    chk("set_min_mode", {mode, blink}, {3'd2, 1'b0});
    btn_up = 1; cyc();
    chk("min_up", {min_en, hour_en}, 2'b10);
    btn_mode = 1; btn_up = 1; cyc();
    chk("mode_wins", {mode, min_en, alm_hour_en}, {3'd3, 2'b00});
    btn_down = 1; cyc();
    chk("almhr_down", {alm_hour_en, cnt_dir}, 2'b10);
    btn_mode = 1; cyc();
    chk("set_almmin_mode", mode, 4);
    btn_down = 1; cyc();
    chk("almmin_down", {alm_min_en, alm_hour_en, cnt_dir}, 3'b100);
    btn_alarm = 1; cyc();
    chk("set_alarm_ignored", alarm_armed, 0);
    btn_mode = 1; cyc();
    chk("back_clock", {mode, cnt_dir}, {3'd0, 1'b0});
    tick_1hz = 1; cyc();
    chk("tick_dir_up", {sec_en, cnt_dir}, 2'b11);

    // Arm and ring until auto-silence
    btn_alarm = 1; cyc();
    chk("armed", alarm_armed, 1);
    alarm_match = 1; cyc();
    chk("ring_mode", {mode, buzzer}, {3'd5, 1'b1});
    btn_mode = 1; cyc();
    chk("ring_mode_ignored", mode, 5);
    for (int i = 0; i < 59; i++) begin
      tick_1hz = 1; cyc();
    end
    chk("ring_59", {mode, buzzer}, {3'd5, 1'b1});
    tick_1hz = 1; cyc();
    chk("ring_60", {mode, buzzer, alarm_armed}, {3'd0, 1'b0, 1'b1});
    chk("ring_60_count", sec_en, 1);
    cyc(); cyc();
    chk("no_retrigger", mode, 0);

    // Silence by button after 3 ticks
    alarm_match = 0; cyc();
    alarm_match = 1; cyc();
    chk("ring2_mode", mode, 5);
    for (int i = 0; i < 3; i++) begin
      tick_1hz = 1; cyc();
    end
    btn_alarm = 1; cyc();
    chk("silence", {mode, buzzer, alarm_armed}, {3'd0, 1'b0, 1'b1});

    // Reset during ringing
    alarm_match = 0; cyc();
    alarm_match = 1; cyc();
    chk("ring3_buzz", buzzer, 1);
    reset = 1; cyc();
    chk("ring_reset", {mode, buzzer, alarm_armed}, {3'd0, 1'b0, 1'b0});
    reset = 0; cyc();

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
